// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default prescaler, data width.
// Defining UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;
    localparam int DEFAULT_P = 10416;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level.
module uart_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, mid-bit sampling with a P-cycle bit timer.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int P = DEFAULT_P
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err
);
    localparam int               CNT_W     = $clog2(P);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(P / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(P - 1);

    state_t            state;
    state_t            next_state;
    logic              rx;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              tick;
    logic              shift_en;
    logic              load_out;
    logic              ferr_set;
`ifdef UART_RX_PARITY_EN
    logic              par_en;
    logic              par_bad;
    logic              perr_set;
`endif

    uart_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (in),
        .q     (rx)
    );

    always_comb begin
        next_state = state;
        tick       = 1'b0;
        shift_en   = 1'b0;
        load_out   = 1'b0;
        ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
        perr_set   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx) next_state = S_START;
            end
            // A start bit that is no longer low at mid-bit is treated as a glitch.
            S_START: begin
                if (cnt == HALF_LAST) begin
                    tick       = 1'b1;
                    next_state = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_LAST) begin
                    tick     = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == FULL_LAST) begin
                    tick       = 1'b1;
                    par_en     = 1'b1;
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == FULL_LAST) begin
                    tick = 1'b1;
                    if (rx) begin
                        next_state = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_set   = par_bad;
                        load_out   = !par_bad;
`else
                        load_out   = 1'b1;
`endif
                    end else begin
                        next_state = S_WAIT_IDLE;
                        ferr_set   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_set   = par_bad;
`endif
                    end
                end
            end
            // A held-low line (break) stays here, so it reports only one frame error.
            S_WAIT_IDLE: begin
                if (rx) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            out        <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            valid      <= load_out;
            frame_err  <= ferr_set;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_set;
`endif
            if (state == S_IDLE || state == S_WAIT_IDLE || tick) cnt <= '0;
            else                                                 cnt <= cnt + CNT_W'(1);
            if (state == S_IDLE)  bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (load_out) out <= shreg;
        end
    end

    // Data-only registers: contents are meaningless until the frame that fills them.
    always_ff @(posedge clock) begin
        if (shift_en) shreg <= {rx, shreg[DATA_W-1:1]};
`ifdef UART_RX_PARITY_EN
        if (par_en) par_bad <= rx ^ even_parity(shreg);
`endif
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-timing reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames, glitches and breaks.
module tb_uart_rx;
    localparam int P = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 9 : 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in    = 1'b1;
    logic [7:0] out;
    logic       valid, busy, frame_err, parity_err;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    uart_rx #(.P(P)) dut (
        .clock      (clock),
        .reset      (reset),
        .in         (in),
        .out        (out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    // Reference model: line value seen two edges late, frame decoded from sample times
    // measured relative to the detected falling edge t0.
    int         cyc = 0;
    int         mode = 0;          // 0 idle, 1 receiving frame, 2 waiting for line high
    int         t0 = 0;
    logic       m_d1, m_d2;
    logic [7:0] m_data;
    logic       m_par;
    logic [7:0] e_out;
    logic       e_valid, e_ferr, e_perr, e_busy;

    task automatic model_step();
        logic rxn;
        logic bad;
        int   rel;
        int   k;
        cyc++;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_perr  = 1'b0;
        if (reset) begin
            m_d1  = 1'b1;
            m_d2  = 1'b1;
            mode  = 0;
            e_out = 8'h00;
        end else begin
            rxn  = m_d2;
            m_d2 = m_d1;
            m_d1 = in;
            if (mode == 0) begin
                if (!rxn) begin
                    t0   = cyc;
                    mode = 1;
                end
            end else if (mode == 1) begin
                rel = cyc - t0;
                if (rel == P / 2 && rxn) begin
                    mode = 0;
                end else if (rel > P / 2 && (rel - P / 2) % P == 0) begin
                    k = (rel - P / 2) / P - 1;
                    if (k < 8) begin
                        m_data[k] = rxn;
                    end else if (PAR && k == 8) begin
                        m_par = rxn;
                    end else begin
                        bad = PAR && (m_par != ^m_data);
                        if (rxn) begin
                            if (bad) e_perr = 1'b1;
                            else begin
                                e_valid = 1'b1;
                                e_out   = m_data;
                            end
                            mode = 0;
                        end else begin
                            e_ferr = 1'b1;
                            e_perr = bad;
                            mode   = 2;
                        end
                    end
                end
            end else begin
                if (rxn) mode = 0;
            end
        end
        e_busy = (mode != 0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Per-cycle comparison and pulse bookkeeping, on the inactive edge.
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    int         last_valid_cyc = 0;
    logic [7:0] vals[$];

    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                vectors++;
                if ({out, valid, busy, frame_err, parity_err} !==
                    {e_out, e_valid, e_busy, e_ferr, e_perr}) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got out=%h valid=%b busy=%b frame_err=%b parity_err=%b, want out=%h valid=%b busy=%b frame_err=%b parity_err=%b",
                             cyc, out, valid, busy, frame_err, parity_err,
                             e_out, e_valid, e_busy, e_ferr, e_perr);
                end
                if (valid) begin
                    n_valid++;
                    vals.push_back(out);
                    last_valid_cyc = cyc;
                end
                if (frame_err)  n_ferr++;
                if (parity_err) n_perr++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        in = b;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop, input int stop_len);
        hold(1'b0, P);
        for (int i = 0; i < 8; i++) hold(d[i], P);
        if (PAR) hold(par, P);
        hold(stop, stop_len);
    endtask

    initial begin
        int         t_drive;
        int         nv;
        logic [7:0] b;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checking = 1'b1;
        check("reset_out", out, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        reset = 1'b0;
        hold(1'b1, 5);

        // Single byte 0xA5
        t_drive = cyc;
        b = 8'hA5;
        send(b, ^b, 1'b1, P);
        hold(1'b1, P);
        check("a5_count", n_valid, 1);
        check("a5_value", vals[0], 8'hA5);
        check("a5_latency", last_valid_cyc - t_drive, PAR ? 171 : 155);
        check("a5_ferr", n_ferr, 0);

        // Back-to-back 0x00, 0xFF with exactly one bit of stop
        send(8'h00, 1'b0, 1'b1, P);
        send(8'hFF, 1'b0, 1'b1, P);
        hold(1'b1, 2 * P);
        check("b2b_count", n_valid, 3);
        check("b2b_first", vals[1], 8'h00);
        check("b2b_second", vals[2], 8'hFF);

        // Short glitch on idle line
        t_drive = cyc;
        hold(1'b0, 3);
        hold(1'b1, 4);
        check("glitch_busy_mid", busy, 1);
        hold(1'b1, 5);
        check("glitch_busy_after", busy, 0);
        check("glitch_no_valid", n_valid, 3);
        check("glitch_no_ferr", n_ferr, 0);

        // 0x3C with stop forced low and the line held low for 40 cycles
        b = 8'h3C;
        send(b, ^b, 1'b0, 30);
        check("break_busy_low", busy, 1);
        hold(1'b0, 10);
        hold(1'b1, P);
        check("break_ferr_once", n_ferr, 1);
        check("break_out_kept", out, 8'hFF);
        check("break_busy_idle", busy, 0);
        check("break_no_valid", n_valid, 3);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b0, 1'b1, P);
        hold(1'b1, P);
        check("par_bad_perr", n_perr, 1);
        check("par_bad_novalid", n_valid, 3);
        send(8'h07, 1'b1, 1'b1, P);
        hold(1'b1, P);
        check("par_ok_valid", n_valid, 4);
        check("par_ok_out", out, 8'h07);
`endif

        // Reset during bit 4 of 0x5A
        nv = n_valid;
        b  = 8'h5A;
        hold(1'b0, P);
        for (int i = 0; i < 4; i++) hold(b[i], P);
        hold(b[4], P / 2);
        reset = 1'b1;
        hold(b[4], 2);
        check("midrst_out", out, 8'h00);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        hold(1'b1, 12 * P);
        check("midrst_no_valid", n_valid, nv);
        b = 8'h81;
        send(b, ^b, 1'b1, P);
        hold(1'b1, 2 * P);
        check("after_rst_count", n_valid, nv + 1);
        check("after_rst_out", out, 8'h81);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            b    = 8'($urandom);
            if (kind == 0) begin
                hold(1'b0, $urandom_range(1, P / 2));
                hold(1'b1, $urandom_range(P, 2 * P));
            end else if (kind == 1) begin
                send(b, ^b, 1'b0, $urandom_range(P, P + 30));
                hold(1'b1, $urandom_range(1, P));
            end else begin
                send(b, ($urandom_range(0, 3) == 0) ? ~(^b) : ^b, 1'b1, $urandom_range(P, 2 * P));
            end
        end
        hold(1'b1, 3 * P);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: P, 10416, prescaler in clock cycles per bit (SYSCLK/BaudRate); legal range 4..65535, even values only.
REQ-002 SHALL have port: clock  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port: out  output  8  last correctly received byte.
REQ-006 SHALL have port: valid  output  1  one-cycle pulse when out is updated.
REQ-007 SHALL have port: busy  output  1  high while any state other than IDLE is active.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port: parity_err  output  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

Function
REQ-010 SHALL pass in through a 2-flop synchronizer; all further references to rx mean the synchronizer output.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (present only with UART_RX_PARITY_EN), STOP and WAIT_IDLE.
REQ-012 IDLE: on rx=0, SHALL enter START and clear the bit counter; define t0 as this edge.
REQ-013 START: at t0+P/2 SHALL sample rx; if 0, enter DATA; if 1 (glitch), return to IDLE with no pulse.
REQ-014 DATA: SHALL sample bit k (k=0..7, LSB first) at t0+P/2+(k+1)*P into a shift register.
REQ-015 After bit 7, SHALL enter PARITY when compiled in, otherwise STOP.
REQ-016 PARITY: SHALL sample at t0+P/2+9*P; the expected value is even parity (XOR of the 8 data bits).
REQ-017 STOP: SHALL sample one bit period after the last data or parity sample.
REQ-018 Stop=1 with no parity error: on the sampling edge, out SHALL load the shift register and valid SHALL pulse; the next state is IDLE.
REQ-019 Stop=1 with a parity error: parity_err SHALL pulse, out is unchanged and valid stays 0; the next state is IDLE.
REQ-020 Stop=0: frame_err SHALL pulse (and parity_err too if mismatched), out is unchanged; the next state is WAIT_IDLE.
REQ-021 WAIT_IDLE: SHALL hold until rx=1 for one cycle, then enter IDLE; break conditions produce exactly one frame_err.
REQ-022 A new start bit SHALL be accepted in the first cycle back in IDLE (half-stop-bit tolerance).
REQ-023 valid, frame_err and parity_err SHALL never be high for more than one consecutive cycle.
REQ-024 The bit-period counter SHALL be wide enough for P-1 and SHALL reset to 0 at every sample point.

Reset
REQ-025 On reset=1, SHALL set state=IDLE, counters=0, out=8'h00, valid=0, busy=0, frame_err=0, parity_err=0, and both synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abort the frame with no pulse; reception restarts only on a fresh falling edge after reset deasserts.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: the PARITY state and even-parity check are included, and the frame is 11 bits.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state, the frame is 10 bits, and parity_err is tied 0.

Structure
REQ-029 Package uart_pkg SHALL hold the state enumeration, the default prescaler constant (10416) and the data width constant (8).
REQ-030 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for in.

Verification (P=16 for simulation)
REQ-031 Bench SHALL cover: byte 8'hA5 sent 8N1 -> a single valid pulse, out=8'hA5 at t0+8+9*16, frame_err=0.
REQ-032 Bench SHALL cover: 8'h00 then 8'hFF back-to-back with a stop bit of exactly P -> two valid pulses, out=8'h00 then 8'hFF.
REQ-033 Bench SHALL cover: a 3-cycle low glitch on an idle line -> return to IDLE, no pulses, busy low after t0+8.
REQ-034 Bench SHALL cover: 8'h3C with the stop bit forced low, line held low for 40 cycles -> one frame_err pulse, out unchanged, busy high until rx rises.
REQ-035 Bench SHALL cover (parity build): 8'h07 with parity bit 0 -> parity_err pulses, valid=0; with parity bit 1 -> valid pulses, out=8'h07.
REQ-036 Bench SHALL cover: reset asserted during bit 4 of 8'h5A -> no valid, all outputs at reset values, and the next frame 8'h81 is received correctly.
